// File: rtl/day_counter_if.sv
// -----------------------------------------------------------------------------
// day_counter_if
// Groups the day counter's calendar-side signals into one bundle.
//   Inputs to the counter : ClkDay, DayOverPlus, DayOverMinus (one-cycle pulses),
//                           KeyPlus, KeyMinus (active-low buttons), EditMode,
//                           EditPos[2:0], screen[1:0], months[6:0], years[13:0]
//   Outputs of the counter: days[6:0], ClkMonth, MonthOverPlus, MonthOverMinus
// master : the environment (hour/month/year counters, keys, edit controller)
// slave  : the day counter itself
// -----------------------------------------------------------------------------
interface day_counter_if;
    logic        ClkDay;
    logic        DayOverPlus;
    logic        DayOverMinus;
    logic        KeyPlus;
    logic        KeyMinus;
    logic        EditMode;
    logic [2:0]  EditPos;
    logic [1:0]  screen;
    logic [6:0]  months;
    logic [13:0] years;
    logic [6:0]  days;
    logic        ClkMonth;
    logic        MonthOverPlus;
    logic        MonthOverMinus;

    modport master (
        output ClkDay, DayOverPlus, DayOverMinus, KeyPlus, KeyMinus,
        output EditMode, EditPos, screen, months, years,
        input  days, ClkMonth, MonthOverPlus, MonthOverMinus
    );

    modport slave (
        input  ClkDay, DayOverPlus, DayOverMinus, KeyPlus, KeyMinus,
        input  EditMode, EditPos, screen, months, years,
        output days, ClkMonth, MonthOverPlus, MonthOverMinus
    );
endinterface

// File: rtl/day_counter.sv
// -----------------------------------------------------------------------------
// day_counter
// Day-of-month counter between the hour counter and the month counter.
// Advances on the hour counter's day carry (run mode), steps on time-zone
// shift pulses and on Edit Mode key presses (edit mode), and generates the
// month counter's carry / time-zone overflow pulses. All outputs registered.
//
// Ports:
//   clk    in  main clock, rising edge
//   reset  in  asynchronous, active-low reset
//   bus    day_counter_if.slave (see interface for the signal list)
//
// Configuration macro:
//   DAY_LEAP_YEAR_EN  defined    : February has 29 days in leap years
//                     undefined  : February is always 28 days, years unused
// -----------------------------------------------------------------------------
module day_counter (
    input  logic          clk,
    input  logic          reset,
    day_counter_if.slave  bus
);

    // Month length; anything outside 1..12 is treated as a 31-day month.
    function automatic logic [6:0] month_len(input logic [6:0] m, input logic leap);
        case (m)
            7'd2:                    month_len = leap ? 7'd29 : 7'd28;
            7'd4, 7'd6, 7'd9, 7'd11: month_len = 7'd30;
            default:                 month_len = 7'd31;
        endcase
    endfunction

    logic leap;

`ifdef DAY_LEAP_YEAR_EN
    assign leap = ((bus.years % 14'd4) == 14'd0) &&
                  (((bus.years % 14'd100) != 14'd0) || ((bus.years % 14'd400) == 14'd0));
`else
    logic unused_years;
    assign unused_years = ^bus.years;
    assign leap         = 1'b0;
`endif

    logic [6:0] max_days;
    logic [6:0] prev_max;

    assign max_days = month_len(bus.months, leap);
    // January's predecessor is December.
    assign prev_max = (bus.months == 7'd1) ? 7'd31 : month_len(bus.months - 7'd1, leap);

    // State
    logic [6:0] days_q,         days_d;
    logic       clk_month_q,    clk_month_d;
    logic       over_plus_q,    over_plus_d;
    logic       over_minus_q,   over_minus_d;
    logic       key_plus_q,     key_plus_d;
    logic       key_minus_q,    key_minus_d;

    logic plus_fall;
    logic minus_fall;
    logic key_ok;

    // Keys are active-low: a press is a 1 -> 0 transition against last cycle.
    assign plus_fall  = key_plus_q  & ~bus.KeyPlus;
    assign minus_fall = key_minus_q & ~bus.KeyMinus;
    assign key_ok     = bus.EditMode && (bus.screen == 2'd1) && (bus.EditPos == 3'd0);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the if-chain can leave one unassigned and infer a latch.
        days_d       = days_q;
        clk_month_d  = 1'b0;
        over_plus_d  = 1'b0;
        over_minus_d = 1'b0;
        key_plus_d   = bus.KeyPlus;
        key_minus_d  = bus.KeyMinus;

        // Forward steps roll over at ">= max" so a day left above max by a
        // month edit still wraps to 1 instead of leaving the 1..31 range.
        if (bus.ClkDay && !bus.EditMode) begin
            if (days_q >= max_days) begin
                days_d      = 7'd1;
                clk_month_d = 1'b1;
            end else begin
                days_d = days_q + 7'd1;
            end
        end else if (bus.DayOverPlus && bus.EditMode) begin
            if (days_q >= max_days) begin
                days_d      = 7'd1;
                over_plus_d = 1'b1;
            end else begin
                days_d = days_q + 7'd1;
            end
        end else if (bus.DayOverMinus && bus.EditMode) begin
            if (days_q == 7'd1) begin
                days_d       = prev_max;
                over_minus_d = 1'b1;
            end else begin
                days_d = days_q - 7'd1;
            end
        end else if (plus_fall && key_ok) begin
            days_d = (days_q >= max_days) ? 7'd1 : days_q + 7'd1;
        end else if (minus_fall && key_ok) begin
            days_d = (days_q == 7'd1) ? max_days : days_q - 7'd1;
        end else if (!bus.EditMode && (days_q > max_days)) begin
            // Deferred clamp after a month edit made the day invalid.
            days_d = max_days;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            days_q       <= 7'd1;
            clk_month_q  <= 1'b0;
            over_plus_q  <= 1'b0;
            over_minus_q <= 1'b0;
            key_plus_q   <= 1'b1;
            key_minus_q  <= 1'b1;
        end else begin
            days_q       <= days_d;
            clk_month_q  <= clk_month_d;
            over_plus_q  <= over_plus_d;
            over_minus_q <= over_minus_d;
            key_plus_q   <= key_plus_d;
            key_minus_q  <= key_minus_d;
        end
    end

    assign bus.days           = days_q;
    assign bus.ClkMonth       = clk_month_q;
    assign bus.MonthOverPlus  = over_plus_q;
    assign bus.MonthOverMinus = over_minus_q;

endmodule

// File: tb/tb_day_counter.sv
`timescale 1ns/1ps
module tb_day_counter;

    logic clk;
    logic reset;

    day_counter_if bus ();

    day_counter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clk_day;
        logic        dop;
        logic        dom;
        logic        kp;
        logic        km;
        logic        edit;
        logic [2:0]  pos;
        logic [1:0]  scr;
        logic [6:0]  mon;
        logic [13:0] yr;
    } stim_t;

    typedef struct packed {
        logic [6:0] days;
        logic       cm;
        logic       mop;
        logic       mom;
    } exp_t;

    stim_t cur;
    exp_t  exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_days = 1;
    bit m_kp   = 1'b1;
    bit m_km   = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit is_leap(input int y);
`ifdef DAY_LEAP_YEAR_EN
        return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int month_len(input int m, input int y);
        int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m < 1 || m > 12) return 31;
        if (m == 2 && is_leap(y)) return 29;
        return tbl[m-1];
    endfunction

    function automatic int prev_len(input int m, input int y);
        return (m == 1) ? 31 : month_len(m - 1, y);
    endfunction

    task automatic drive();
        bus.ClkDay       = cur.clk_day;
        bus.DayOverPlus  = cur.dop;
        bus.DayOverMinus = cur.dom;
        bus.KeyPlus      = cur.kp;
        bus.KeyMinus     = cur.km;
        bus.EditMode     = cur.edit;
        bus.EditPos      = cur.pos;
        bus.screen       = cur.scr;
        bus.months       = cur.mon;
        bus.years        = cur.yr;
    endtask

    // Calendar rules applied to the current inputs; result goes to the scoreboard.
    task automatic model_step();
        int   mx;
        int   pm;
        bit   pf;
        bit   mf;
        bit   kok;
        exp_t e;
        mx  = month_len(int'(cur.mon), int'(cur.yr));
        pm  = prev_len(int'(cur.mon), int'(cur.yr));
        pf  = m_kp && !cur.kp;
        mf  = m_km && !cur.km;
        kok = cur.edit && cur.scr == 2'd1 && cur.pos == 3'd0;
        e   = '0;
        if (cur.clk_day && !cur.edit) begin
            e.cm   = (m_days == mx);
            m_days = m_days % mx + 1;
        end else if (cur.dop && cur.edit) begin
            e.mop  = (m_days == mx);
            m_days = m_days % mx + 1;
        end else if (cur.dom && cur.edit) begin
            e.mom  = (m_days == 1);
            m_days = (m_days == 1) ? pm : m_days - 1;
        end else if (pf && kok) begin
            m_days = m_days % mx + 1;
        end else if (mf && kok) begin
            m_days = (m_days == 1) ? mx : m_days - 1;
        end else if (!cur.edit && m_days > mx) begin
            m_days = mx;
        end
        e.days = 7'(m_days);
        m_kp   = cur.kp;
        m_km   = cur.km;
        exp_q.push_back(e);
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic cycle();
        drive();
        model_step();
        cur.clk_day = 1'b0;
        cur.dop     = 1'b0;
        cur.dom     = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_now(input string name, input int d, input bit cm, input bit mop, input bit mom);
        check({name, ".days"}, 32'(bus.days), 32'(d));
        check({name, ".ClkMonth"}, 32'(bus.ClkMonth), 32'(cm));
        check({name, ".MonthOverPlus"}, 32'(bus.MonthOverPlus), 32'(mop));
        check({name, ".MonthOverMinus"}, 32'(bus.MonthOverMinus), 32'(mom));
    endtask

    // Reach a given day with key presses in January (31 days).
    task automatic goto_day(input int target);
        int guard = 0;
        cur.edit = 1'b1;
        cur.scr  = 2'd1;
        cur.pos  = 3'd0;
        cur.mon  = 7'd1;
        cur.kp   = 1'b1;
        cur.km   = 1'b1;
        while (m_days != target && guard < 40) begin
            cur.kp = 1'b0;
            cycle();
            cur.kp = 1'b1;
            cycle();
            guard++;
        end
        check("goto_day_reached", 32'(bus.days), 32'(target));
    endtask

    task automatic rand_cycle();
        int mx;
        if ($urandom_range(0, 19) == 0) cur.edit = ~cur.edit;
        cur.mon = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(1, 12));
        case ($urandom_range(0, 4))
            0:       cur.yr = 14'd2000;
            1:       cur.yr = 14'd1900;
            2:       cur.yr = 14'd2024;
            3:       cur.yr = 14'd2023;
            default: cur.yr = 14'($urandom_range(0, 9999));
        endcase
        cur.pos     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        cur.scr     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
        cur.clk_day = ($urandom_range(0, 3) == 0);
        cur.dop     = ($urandom_range(0, 5) == 0);
        cur.dom     = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 2) == 0) cur.kp = ~cur.kp;
        if ($urandom_range(0, 2) == 0) cur.km = ~cur.km;
        // Keep forward steps away from a day already above this month's length.
        mx = month_len(int'(cur.mon), int'(cur.yr));
        if (m_days > mx) begin
            cur.clk_day = 1'b0;
            cur.dop     = 1'b0;
            cur.kp      = m_kp;
        end
        cycle();
    endtask

    // Monitor: compares every registered output update against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb.days", 32'(bus.days), 32'(e.days));
                check("sb.ClkMonth", 32'(bus.ClkMonth), 32'(e.cm));
                check("sb.MonthOverPlus", 32'(bus.MonthOverPlus), 32'(e.mop));
                check("sb.MonthOverMinus", 32'(bus.MonthOverMinus), 32'(e.mom));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cur = '{clk_day: 1'b0, dop: 1'b0, dom: 1'b0, kp: 1'b1, km: 1'b1, edit: 1'b0,
                pos: 3'd0, scr: 2'd1, mon: 7'd1, yr: 14'd2000};
        drive();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        expect_now("reset", 1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Run-mode rollover in January, then 30 more days without a carry.
        goto_day(31);
        cur.edit    = 1'b0;
        cur.clk_day = 1'b1;
        cycle();
        expect_now("jan_rollover", 1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            cycle();
            cur.clk_day = 1'b1;
            cycle();
        end
        expect_now("jan_count_up", 31, 1'b0, 1'b0, 1'b0);

        // February 28th in several years.
        goto_day(28);
        cur.mon = 7'd2; cur.yr = 14'd2024; cur.edit = 1'b0; cur.clk_day = 1'b1;
        cycle();
`ifdef DAY_LEAP_YEAR_EN
        expect_now("feb_2024", 29, 1'b0, 1'b0, 1'b0);
`else
        expect_now("feb_2024", 1, 1'b1, 1'b0, 1'b0);
`endif
        goto_day(28);
        cur.mon = 7'd2; cur.yr = 14'd1900; cur.edit = 1'b0; cur.clk_day = 1'b1;
        cycle();
        expect_now("feb_1900", 1, 1'b1, 1'b0, 1'b0);
        goto_day(28);
        cur.mon = 7'd2; cur.yr = 14'd2000; cur.edit = 1'b0; cur.clk_day = 1'b1;
        cycle();
`ifdef DAY_LEAP_YEAR_EN
        expect_now("feb_2000", 29, 1'b0, 1'b0, 1'b0);
`else
        expect_now("feb_2000", 1, 1'b1, 1'b0, 1'b0);
`endif

        // Time-zone step back across a month boundary.
        goto_day(1);
        cur.mon = 7'd3; cur.yr = 14'd2000; cur.dom = 1'b1;
        cycle();
`ifdef DAY_LEAP_YEAR_EN
        expect_now("tz_minus_mar", 29, 1'b0, 1'b0, 1'b1);
`else
        expect_now("tz_minus_mar", 28, 1'b0, 1'b0, 1'b1);
`endif
        cycle();
        goto_day(1);
        cur.dom = 1'b1;
        cycle();
        expect_now("tz_minus_jan", 31, 1'b0, 1'b0, 1'b1);

        // Held keys in April.
        goto_day(30);
        cur.mon = 7'd4; cur.kp = 1'b0;
        repeat (10) cycle();
        expect_now("key_plus_held", 1, 1'b0, 1'b0, 1'b0);
        cur.kp = 1'b1; cycle();
        cur.km = 1'b0; cycle();
        expect_now("key_minus", 30, 1'b0, 1'b0, 1'b0);
        cur.km = 1'b1; cycle();
        cur.pos = 3'd2; cur.kp = 1'b0; cycle();
        expect_now("key_wrong_pos", 30, 1'b0, 1'b0, 1'b0);
        cur.kp = 1'b1; cycle();
        cur.pos = 3'd0;

        // Deferred clamp on leaving Edit Mode; ClkDay ignored in Edit Mode.
        goto_day(31);
        cur.mon = 7'd6; cycle();
        expect_now("edit_hold_31", 31, 1'b0, 1'b0, 1'b0);
        cur.edit = 1'b0; cycle();
        expect_now("clamp_june", 30, 1'b0, 1'b0, 1'b0);
        cur.edit = 1'b1; cur.clk_day = 1'b1; cycle();
        expect_now("clkday_in_edit", 30, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a DayOverPlus pulse.
        goto_day(31);
        cur.dop = 1'b1;
        drive();
        #2;
        reset = 1'b0;
        #1;
        expect_now("async_reset", 1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        cur.dop = 1'b0;
        cur.kp  = 1'b1;
        cur.km  = 1'b1;
        m_days  = 1;
        m_kp    = 1'b1;
        m_km    = 1'b1;
        reset   = 1'b1;
        cycle();
        expect_now("after_reset", 1, 1'b0, 1'b0, 1'b0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) rand_cycle();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
